// File: rtl/mem_issue_ctrl.sv
// In-order load issue controller: circular load queue feeding one memory FU,
// with single in-flight load tracking and branch-mispredict squash.
module mem_issue_ctrl #(
    parameter int DEPTH    = 4,
    parameter int ROB_SIZE = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    input  logic [4:0]               enq_rob,
    input  logic [6:0]               enq_pd,
    input  logic [31:0]              enq_base,
    input  logic [31:0]              enq_imm,
    input  logic [2:0]               enq_func3,
    input  logic [4:0]               curr_rob_tag,
    input  logic                     mispredict,
    input  logic [4:0]               mispredict_tag,
    output logic                     fu_issued,
    output logic [4:0]               fu_rob,
    output logic [6:0]               fu_pd,
    output logic [31:0]              fu_base,
    output logic [31:0]              fu_imm,
    output logic [2:0]               fu_func3,
    input  logic                     fu_ready,
    input  logic                     fu_done,
    input  logic [31:0]              fu_data,
    output logic                     wb_valid,
    output logic [4:0]               wb_rob,
    output logic [6:0]               wb_pd,
    output logic [31:0]              wb_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [4:0]  rob;
        logic [6:0]  pd;
        logic [31:0] base;
        logic [31:0] imm;
        logic [2:0]  func3;
    } ld_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DRAIN
    } state_t;

    ld_t             mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   keep;
    logic [PW-1:0]   scan_idx;
    logic            found;
    state_t          state_q;
    ld_t             inf_q;
    ld_t             enq_entry;
    logic            push;
    logic            pop;
    logic            inf_squash;

    // Tag t is younger than the mispredicted branch but older than the ROB tail.
    function automatic logic in_window(
        input logic [4:0] t,
        input logic [4:0] mt,
        input logic [4:0] ct
    );
        logic [31:0] dt;
        logic [31:0] dc;
        dt = (32'(t) + 32'(ROB_SIZE) - 32'(mt)) % 32'(ROB_SIZE);
        dc = (32'(ct) + 32'(ROB_SIZE) - 32'(mt)) % 32'(ROB_SIZE);
        return (dt != 32'd0) && (dt < dc);
    endfunction

    assign enq_entry = '{
        rob:   enq_rob,
        pd:    enq_pd,
        base:  enq_base,
        imm:   enq_imm,
        func3: enq_func3
    };

    assign enq_ready  = (count_q < CW'(DEPTH)) && !mispredict;
    assign push       = enq_valid && enq_ready;
    assign pop        = (state_q == IDLE) && (count_q != '0)
                        && fu_ready && !mispredict;
    assign inf_squash = mispredict
                        && in_window(inf_q.rob, mispredict_tag, curr_rob_tag);

    // Squashed entries form a youngest suffix: keep everything before the first.
    always_comb begin
        keep     = count_q;
        found    = 1'b0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!found && (CW'(i) < count_q)
                && in_window(mem_q[scan_idx].rob, mispredict_tag,
                             curr_rob_tag)) begin
                keep  = CW'(i);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (mispredict) begin
            tail_d  = head_q + keep[PW-1:0];
            count_d = keep;
        end else begin
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= enq_entry;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            inf_q   <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        inf_q   <= mem_q[head_q];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    state_q <= inf_squash ? DRAIN : WAIT;
                end
                WAIT: begin
                    if (fu_done) begin
                        state_q <= IDLE;
                    end else if (inf_squash) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (fu_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fu_issued = (state_q == ISSUE);
    assign fu_rob    = fu_issued ? inf_q.rob   : '0;
    assign fu_pd     = fu_issued ? inf_q.pd    : '0;
    assign fu_base   = fu_issued ? inf_q.base  : '0;
    assign fu_imm    = fu_issued ? inf_q.imm   : '0;
    assign fu_func3  = fu_issued ? inf_q.func3 : '0;

    assign wb_valid  = (state_q == WAIT) && fu_done && !inf_squash;
    assign wb_rob    = wb_valid ? inf_q.rob : '0;
    assign wb_pd     = wb_valid ? inf_q.pd  : '0;
    assign wb_data   = wb_valid ? fu_data   : '0;

    assign count     = count_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_issue_ctrl.sv
// Bench for mem_issue_ctrl: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_mem_issue_ctrl;

    localparam int DEPTH = 4;
    localparam int RS    = 16;

    typedef struct packed {
        logic [4:0]  rob;
        logic [6:0]  pd;
        logic [31:0] base;
        logic [31:0] imm;
        logic [2:0]  f3;
    } ld_t;

    logic        clk;
    logic        reset;
    logic        enq_valid;
    logic        enq_ready;
    logic [4:0]  enq_rob;
    logic [6:0]  enq_pd;
    logic [31:0] enq_base;
    logic [31:0] enq_imm;
    logic [2:0]  enq_func3;
    logic [4:0]  curr_rob_tag;
    logic        mispredict;
    logic [4:0]  mispredict_tag;
    logic        fu_issued;
    logic [4:0]  fu_rob;
    logic [6:0]  fu_pd;
    logic [31:0] fu_base;
    logic [31:0] fu_imm;
    logic [2:0]  fu_func3;
    logic        fu_ready;
    logic        fu_done;
    logic [31:0] fu_data;
    logic        wb_valid;
    logic [4:0]  wb_rob;
    logic [6:0]  wb_pd;
    logic [31:0] wb_data;
    logic [2:0]  count;
    logic        busy;

    int errs   = 0;
    int checks = 0;

    mem_issue_ctrl #(.DEPTH(DEPTH), .ROB_SIZE(RS)) dut (
        .clk(clk), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_rob(enq_rob), .enq_pd(enq_pd), .enq_base(enq_base),
        .enq_imm(enq_imm), .enq_func3(enq_func3),
        .curr_rob_tag(curr_rob_tag), .mispredict(mispredict),
        .mispredict_tag(mispredict_tag),
        .fu_issued(fu_issued), .fu_rob(fu_rob), .fu_pd(fu_pd),
        .fu_base(fu_base), .fu_imm(fu_imm), .fu_func3(fu_func3),
        .fu_ready(fu_ready), .fu_done(fu_done), .fu_data(fu_data),
        .wb_valid(wb_valid), .wb_rob(wb_rob), .wb_pd(wb_pd),
        .wb_data(wb_data), .count(count), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        enq_valid      = 1'b0;
        enq_rob        = '0;
        enq_pd         = '0;
        enq_base       = '0;
        enq_imm        = '0;
        enq_func3      = '0;
        curr_rob_tag   = '0;
        mispredict     = 1'b0;
        mispredict_tag = '0;
        fu_ready       = 1'b0;
        fu_done        = 1'b0;
        fu_data        = '0;
    endtask

    task automatic do_reset();
        idle_in();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic enq(input int rob, input int pd, input logic [31:0] base,
                       input logic [31:0] imm, input int f3);
        enq_valid = 1'b1;
        enq_rob   = 5'(rob);
        enq_pd    = 7'(pd);
        enq_base  = base;
        enq_imm   = imm;
        enq_func3 = 3'(f3);
    endtask

    task automatic wait_issue(output bit got);
        got = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            if (fu_issued) begin
                got = 1'b1;
                tick();
                return;
            end
            tick();
        end
    endtask

    // Walk the circular interval (mt, ct) exclusive on both ends.
    function automatic bit in_win(input int t, input int mt, input int ct);
        int k;
        k = (mt + 1) % RS;
        for (int n = 0; n < RS; n++) begin
            if (k == ct) return 1'b0;
            if (k == t) return 1'b1;
            k = (k + 1) % RS;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        idle_in();
        reset = 1'b1;
        #3;
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL reset_state count=%0d busy=%0b exp 0/0", count, busy);
        end
        checks++;
        if (fu_issued !== 1'b0 || wb_valid !== 1'b0) begin
            errs++;
            $display("FAIL reset_valids fu_issued=%0b wb_valid=%0b exp 0/0",
                     fu_issued, wb_valid);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (enq_ready !== 1'b1) begin
            errs++;
            $display("FAIL reset_enq_ready got=%0b exp=1", enq_ready);
        end
    endtask

    task automatic test_single_load();
        int iss;
        int niss;
        int nwb;
        do_reset();
        enq(3, 9, 32'h100, 32'd4, 2);
        curr_rob_tag = 5'd4;
        fu_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        iss = -1;
        niss = 0;
        nwb = 0;
        for (int c = 0; c < 12; c++) begin
            fu_done = (iss >= 0 && c == iss + 2);
            fu_data = fu_done ? 32'hDEADBEEF : 32'h0;
            #1;
            if (fu_issued) begin
                niss++;
                iss = c;
                checks++;
                if ({fu_rob, fu_pd, fu_base, fu_imm, fu_func3} !==
                    {5'd3, 7'd9, 32'h100, 32'd4, 3'd2}) begin
                    errs++;
                    $display("FAIL single_issue got rob=%0d pd=%0d base=%h imm=%h exp 3/9/100/4",
                             fu_rob, fu_pd, fu_base, fu_imm);
                end
            end
            if (wb_valid) begin
                nwb++;
                checks++;
                if ({wb_rob, wb_pd, wb_data} !== {5'd3, 7'd9, 32'hDEADBEEF}) begin
                    errs++;
                    $display("FAIL single_wb got rob=%0d pd=%0d data=%h exp 3/9/deadbeef",
                             wb_rob, wb_pd, wb_data);
                end
            end else begin
                checks++;
                if ({wb_rob, wb_pd, wb_data} !== 44'h0) begin
                    errs++;
                    $display("FAIL single_wb_idle got rob=%0d pd=%0d data=%h exp 0",
                             wb_rob, wb_pd, wb_data);
                end
            end
            tick();
        end
        checks++;
        if (niss != 1 || nwb != 1 || busy !== 1'b0) begin
            errs++;
            $display("FAIL single_counts issues=%0d wbs=%0d busy=%0b exp 1/1/0",
                     niss, nwb, busy);
        end
    endtask

    task automatic test_full();
        int n;
        int last;
        bit acc;
        do_reset();
        fu_done = 1'b1;
        for (int i = 0; i < 4; i++) begin
            enq(i + 1, 20 + i, 32'h1000 + 32'(i), 32'd0, 0);
            #1;
            checks++;
            if (enq_ready !== 1'b1 || count !== 3'(i) || wb_valid !== 1'b0) begin
                errs++;
                $display("FAIL full_fill%0d ready=%0b count=%0d wb=%0b exp 1/%0d/0",
                         i, enq_ready, count, wb_valid, i);
            end
            tick();
        end
        enq(5, 24, 32'h1004, 32'd0, 0);
        #1;
        checks++;
        if (enq_ready !== 1'b0 || count !== 3'd4) begin
            errs++;
            $display("FAIL full_block ready=%0b count=%0d exp 0/4", enq_ready, count);
        end
        tick();
        checks++;
        if (count !== 3'd4) begin
            errs++;
            $display("FAIL full_held count=%0d exp=4", count);
        end
        fu_ready = 1'b1;
        n = 0;
        last = 0;
        for (int c = 0; c < 30; c++) begin
            #1;
            if (fu_issued) begin
                checks++;
                if (fu_rob !== 5'(n + 1)) begin
                    errs++;
                    $display("FAIL full_order got=%0d exp=%0d", fu_rob, n + 1);
                end
                if (n > 0) begin
                    checks++;
                    if (c - last != 3) begin
                        errs++;
                        $display("FAIL full_interval got=%0d exp=3", c - last);
                    end
                end
                last = c;
                n++;
            end
            acc = enq_valid && enq_ready;
            tick();
            if (acc) enq_valid = 1'b0;
        end
        checks++;
        if (n != 5 || count !== 3'd0) begin
            errs++;
            $display("FAIL full_total issues=%0d count=%0d exp 5/0", n, count);
        end
    endtask

    task automatic test_flush_queue();
        int n;
        int nwb;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            enq(5 + i, 40 + i, 32'h2000, 32'(i), 1);
            curr_rob_tag = 5'(5 + i);
            tick();
        end
        enq_valid = 1'b0;
        curr_rob_tag = 5'd9;
        mispredict = 1'b1;
        mispredict_tag = 5'd6;
        #1;
        checks++;
        if (enq_ready !== 1'b0 || count !== 3'd4) begin
            errs++;
            $display("FAIL flushq_pre ready=%0b count=%0d exp 0/4", enq_ready, count);
        end
        tick();
        mispredict = 1'b0;
        #1;
        checks++;
        if (count !== 3'd2) begin
            errs++;
            $display("FAIL flushq_count got=%0d exp=2", count);
        end
        fu_ready = 1'b1;
        fu_done = 1'b1;
        n = 0;
        nwb = 0;
        for (int c = 0; c < 15; c++) begin
            #1;
            if (fu_issued) begin
                checks++;
                if (fu_rob !== 5'(5 + n)) begin
                    errs++;
                    $display("FAIL flushq_order got=%0d exp=%0d", fu_rob, 5 + n);
                end
                n++;
            end
            if (wb_valid) nwb++;
            tick();
        end
        checks++;
        if (n != 2 || nwb != 2 || count !== 3'd0) begin
            errs++;
            $display("FAIL flushq_total issues=%0d wbs=%0d count=%0d exp 2/2/0",
                     n, nwb, count);
        end
    endtask

    task automatic test_flush_inflight();
        bit got;
        do_reset();
        enq(14, 3, 32'h3000, 32'd8, 0);
        curr_rob_tag = 5'd15;
        fu_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        wait_issue(got);
        fu_ready = 1'b0;
        checks++;
        if (!got) begin
            errs++;
            $display("FAIL flushinf_issue got=0 exp=1");
        end
        mispredict = 1'b1;
        mispredict_tag = 5'd12;
        curr_rob_tag = 5'd1;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || busy !== 1'b1) begin
            errs++;
            $display("FAIL flushinf_mp wb=%0b busy=%0b exp 0/1", wb_valid, busy);
        end
        tick();
        mispredict = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || fu_issued !== 1'b0) begin
            errs++;
            $display("FAIL flushinf_drain busy=%0b iss=%0b exp 1/0", busy, fu_issued);
        end
        tick();
        fu_done = 1'b1;
        fu_data = 32'hCAFEF00D;
        #1;
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 32'h0) begin
            errs++;
            $display("FAIL flushinf_done wb=%0b data=%h exp 0/0", wb_valid, wb_data);
        end
        tick();
        fu_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL flushinf_idle busy=%0b exp=0", busy);
        end
        enq(2, 4, 32'h40, 32'd0, 0);
        curr_rob_tag = 5'd3;
        fu_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        wait_issue(got);
        fu_ready = 1'b0;
        mispredict = 1'b1;
        mispredict_tag = 5'd1;
        fu_done = 1'b1;
        fu_data = 32'h55AA55AA;
        #1;
        checks++;
        if (!got || wb_valid !== 1'b0) begin
            errs++;
            $display("FAIL done_squash got_issue=%0b wb=%0b exp 1/0", got, wb_valid);
        end
        tick();
        mispredict = 1'b0;
        fu_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL done_squash_idle busy=%0b exp=0", busy);
        end
    endtask

    task automatic test_boundary();
        bit got;
        do_reset();
        enq(5, 11, 32'h200, 32'd8, 3);
        curr_rob_tag = 5'd6;
        fu_ready = 1'b1;
        tick();
        enq_valid = 1'b0;
        wait_issue(got);
        fu_ready = 1'b0;
        mispredict = 1'b1;
        mispredict_tag = 5'd4;
        curr_rob_tag = 5'd5;
        #1;
        checks++;
        if (!got || busy !== 1'b1 || wb_valid !== 1'b0) begin
            errs++;
            $display("FAIL bound_mp issue=%0b busy=%0b wb=%0b exp 1/1/0",
                     got, busy, wb_valid);
        end
        tick();
        mispredict = 1'b0;
        fu_done = 1'b1;
        fu_data = 32'h12345678;
        #1;
        checks++;
        if (wb_valid !== 1'b1 ||
            {wb_rob, wb_pd, wb_data} !== {5'd5, 7'd11, 32'h12345678}) begin
            errs++;
            $display("FAIL bound_wb v=%0b rob=%0d pd=%0d data=%h exp 1/5/11/12345678",
                     wb_valid, wb_rob, wb_pd, wb_data);
        end
        tick();
        fu_done = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errs++;
            $display("FAIL bound_idle busy=%0b exp=0", busy);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        fu_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq(1 + i, 60 + i, 32'h500, 32'(i), 0);
            curr_rob_tag = 5'(2 + i);
            tick();
        end
        enq_valid = 1'b0;
        fu_ready = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b1 || fu_issued !== 1'b0 || count !== 3'd2) begin
            errs++;
            $display("FAIL rstmid_pre busy=%0b iss=%0b count=%0d exp 1/0/2",
                     busy, fu_issued, count);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || busy !== 1'b0) begin
            errs++;
            $display("FAIL rstmid_async count=%0d busy=%0b exp 0/0", count, busy);
        end
        tick();
        reset = 1'b0;
        fu_done = 1'b1;
        fu_data = 32'hFFFF0000;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (wb_valid !== 1'b0 || fu_issued !== 1'b0) begin
                errs++;
                $display("FAIL rstmid_after wb=%0b iss=%0b exp 0/0", wb_valid, fu_issued);
            end
            tick();
        end
        fu_done = 1'b0;
    endtask

    task automatic test_random();
        ld_t mq[$];
        ld_t keepq[$];
        ld_t m_inf;
        ld_t e;
        bit  m_busy;
        bit  m_issue;
        bit  m_dead;
        int  next_tag;
        int  live[$];
        int  mt;
        int  ct;
        bit  exp_ready;
        bit  exp_wbv;
        bit  pop;
        bit  old_busy;
        bit  old_issue;
        logic [78:0] exp_fu;
        logic [43:0] exp_wb;
        do_reset();
        mq.delete();
        m_inf = '0;
        m_busy = 1'b0;
        m_issue = 1'b0;
        m_dead = 1'b0;
        next_tag = 0;
        for (int cyc = 0; cyc < 2500; cyc++) begin
            enq_valid = 1'($urandom_range(0, 1));
            enq_rob   = 5'(next_tag);
            enq_pd    = 7'($urandom);
            enq_base  = $urandom;
            enq_imm   = $urandom;
            enq_func3 = 3'($urandom);
            curr_rob_tag = 5'(next_tag);
            fu_ready  = ($urandom_range(0, 3) != 0);
            fu_done   = ($urandom_range(0, 2) == 0);
            fu_data   = $urandom;
            mispredict = 1'b0;
            mispredict_tag = 5'($urandom_range(0, RS - 1));
            live.delete();
            if (m_busy && !m_dead) live.push_back(int'(m_inf.rob));
            foreach (mq[i]) live.push_back(int'(mq[i].rob));
            if (live.size() > 0 && $urandom_range(0, 11) == 0) begin
                live.push_back((next_tag + RS - 1) % RS);
                mispredict = 1'b1;
                mispredict_tag = 5'(live[$urandom_range(0, live.size() - 1)]);
            end
            mt = int'(mispredict_tag);
            ct = next_tag;
            #1;
            exp_ready = (mq.size() < DEPTH) && !mispredict;
            exp_fu = (m_busy && m_issue) ? m_inf : '0;
            exp_wbv = m_busy && !m_issue && !m_dead && fu_done
                      && !(mispredict && in_win(int'(m_inf.rob), mt, ct));
            exp_wb = exp_wbv ? {m_inf.rob, m_inf.pd, fu_data} : '0;
            checks++;
            if (enq_ready !== exp_ready || count !== 3'(mq.size())
                || busy !== m_busy) begin
                errs++;
                $display("FAIL rnd_status cyc=%0d ready=%0b count=%0d busy=%0b exp %0b/%0d/%0b",
                         cyc, enq_ready, count, busy, exp_ready, mq.size(), m_busy);
            end
            checks++;
            if (fu_issued !== (m_busy && m_issue) ||
                {fu_rob, fu_pd, fu_base, fu_imm, fu_func3} !== exp_fu) begin
                errs++;
                $display("FAIL rnd_issue cyc=%0d iss=%0b rob=%0d exp iss=%0b rob=%0d",
                         cyc, fu_issued, fu_rob, m_busy && m_issue, exp_fu[78:74]);
            end
            checks++;
            if (wb_valid !== exp_wbv || {wb_rob, wb_pd, wb_data} !== exp_wb) begin
                errs++;
                $display("FAIL rnd_wb cyc=%0d v=%0b rob=%0d data=%h exp v=%0b rob=%0d data=%h",
                         cyc, wb_valid, wb_rob, wb_data, exp_wbv, exp_wb[43:39],
                         exp_wb[31:0]);
            end
            old_busy = m_busy;
            old_issue = m_issue;
            pop = !old_busy && mq.size() > 0 && fu_ready && !mispredict;
            if (mispredict) begin
                keepq.delete();
                foreach (mq[i])
                    if (!in_win(int'(mq[i].rob), mt, ct)) keepq.push_back(mq[i]);
                mq = keepq;
                if (m_busy && in_win(int'(m_inf.rob), mt, ct)) m_dead = 1'b1;
            end
            if (old_busy) begin
                if (old_issue) m_issue = 1'b0;
                else if (fu_done) m_busy = 1'b0;
            end
            if (pop) begin
                m_inf = mq.pop_front();
                m_busy = 1'b1;
                m_issue = 1'b1;
                m_dead = 1'b0;
            end
            if (enq_valid && exp_ready) begin
                e = '{rob: enq_rob, pd: enq_pd, base: enq_base,
                      imm: enq_imm, f3: enq_func3};
                mq.push_back(e);
            end
            if (mispredict) next_tag = (mt + 1) % RS;
            else if (enq_valid && exp_ready) next_tag = (next_tag + 1) % RS;
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_full();
        test_flush_queue();
        test_flush_inflight();
        test_boundary();
        test_reset_mid_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_issue_ctrl.md
MEM_ISSUE_CTRL -- requirements
Module: mem_issue_ctrl

Interface
REQ-001 SHALL have parameter: DEPTH, 4, load-queue entries (power of 2, >=2).
REQ-002 SHALL have parameter: ROB_SIZE, 16, ROB entries; tags wrap 15 -> 0.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: enq_valid in 1, enq_ready out 1; dispatch handshake, transfer when both high at clk.
REQ-006 SHALL have ports: enq_rob in 5, enq_pd in 7, enq_base in 32, enq_imm in 32, enq_func3 in 3; load fields captured on transfer.
REQ-007 SHALL have ports: curr_rob_tag in 5, mispredict in 1, mispredict_tag in 5; ROB tail and branch-flush request.
REQ-008 SHALL have ports: fu_issued out 1, fu_rob out 5, fu_pd out 7, fu_base out 32, fu_imm out 32, fu_func3 out 3; issue to memory FU.
REQ-009 SHALL have ports: fu_ready in 1, fu_done in 1, fu_data in 32; memory FU status and result.
REQ-010 SHALL have ports: wb_valid out 1, wb_rob out 5, wb_pd out 7, wb_data out 32; writeback toward PRF/ROB.
REQ-011 SHALL have ports: count out $clog2(DEPTH)+1 queued entries, busy out 1 high when state != IDLE.

Function
REQ-012 Queue SHALL be in-order circular FIFO (head/tail pointers, count); enq_ready = (count < DEPTH) && !mispredict.
REQ-013 FSM SHALL have states IDLE, ISSUE, WAIT, DRAIN.
REQ-014 IDLE -> ISSUE when count > 0, fu_ready = 1 and no mispredict; head entry popped into in-flight register on that edge.
REQ-015 ISSUE SHALL last exactly one cycle with fu_issued = 1 and fu_* driven from in-flight register; ISSUE -> WAIT.
REQ-016 WAIT -> IDLE on fu_done = 1; same cycle wb_valid = 1, wb_rob/wb_pd = in-flight fields, wb_data = fu_data (combinational, one-cycle pulse).
REQ-017 Minimum issue-to-issue interval SHALL be 3 cycles (ISSUE, WAIT with done, IDLE); only one load in flight.
REQ-018 Tag t is squashed when t lies strictly inside circular interval (mispredict_tag, curr_rob_tag) mod ROB_SIZE; none squashed when mispredict_tag+1 mod ROB_SIZE == curr_rob_tag.
REQ-019 On mispredict, all squashed queue entries SHALL be removed in that cycle: tail rewinds to oldest squashed entry, count reduced accordingly (squashed entries are always a contiguous youngest suffix).
REQ-020 On mispredict with in-flight entry squashed: ISSUE or WAIT -> DRAIN; wb_valid suppressed.
REQ-021 DRAIN -> IDLE on fu_done; result discarded, wb_valid stays 0.
REQ-022 fu_done and squash of in-flight entry in same cycle: no writeback, state -> IDLE.
REQ-023 Enqueue and issue-pop in same cycle SHALL both occur; count unchanged.
REQ-024 fu_done in IDLE SHALL be ignored.
REQ-025 Pointers SHALL wrap modulo DEPTH; full (count == DEPTH) blocks enqueue, empty blocks issue.
REQ-026 Outputs fu_*, wb_rob/pd/data SHALL be 0 when corresponding valid is 0.

Reset
REQ-027 reset SHALL asynchronously force state IDLE, head = tail = count = 0, in-flight register 0, fu_issued = 0, wb_valid = 0, enq_ready = 1 after release.
REQ-028 Reset mid-load SHALL discard in-flight and queued entries; no writeback follows even if fu_done arrives later.

Verification
REQ-029 Single load: enq rob=3, pd=9, base=0x100, imm=4, fu_ready=1, fu_done 2 cycles after issue with data 0xDEADBEEF -> one fu_issued pulse (base 0x100, imm 4), one wb_valid with rob=3, pd=9, data 0xDEADBEEF.
REQ-030 Full: 5 back-to-back enqs, fu_ready=0 -> enq_ready low after 4th, count=4, 5th held; raising fu_ready issues in rob order.
REQ-031 Flush queue: queue rob 5,6,7,8, curr_rob_tag=9, mispredict_tag=6 -> 7,8 removed, count=2, later issues only 5,6.
REQ-032 Flush in-flight: rob 14 in WAIT, mispredict_tag=12, curr_rob_tag=1 (wrap) -> DRAIN; fu_done gives no wb_valid; back to IDLE.
REQ-033 Boundary: mispredict_tag=4, curr_rob_tag=5 -> nothing squashed, in-flight completes normally.
REQ-034 Reset asserted in WAIT with 2 queued -> count=0, busy=0 immediately; subsequent fu_done -> no wb_valid.
